// File: rtl/exec_pkg.sv
// Shared definitions for the exec_controller slice: default widths,
// opcode values and FSM state type.
// Optional feature macro: STATUS_FLAGS_EN (see exec_controller.sv).
package exec_pkg;

   localparam int unsigned DEF_DATA_W     = 8;
   localparam int unsigned DEF_REG_ADDR_W = 2;
   localparam int unsigned DEF_OPC_W      = 4;
   localparam int unsigned INSTR_W        = DEF_OPC_W + 2 * DEF_REG_ADDR_W + DEF_DATA_W;

   localparam logic [DEF_OPC_W-1:0] OPC_NOP = 4'd0;
   localparam logic [DEF_OPC_W-1:0] OPC_ADD = 4'd1;
   localparam logic [DEF_OPC_W-1:0] OPC_SUB = 4'd2;
   localparam logic [DEF_OPC_W-1:0] OPC_AND = 4'd3;
   localparam logic [DEF_OPC_W-1:0] OPC_OR  = 4'd4;
   localparam logic [DEF_OPC_W-1:0] OPC_XOR = 4'd5;
   localparam logic [DEF_OPC_W-1:0] OPC_LDI = 4'd6;
   localparam logic [DEF_OPC_W-1:0] OPC_MOV = 4'd7;
   localparam logic [DEF_OPC_W-1:0] OPC_SHL = 4'd8;
   localparam logic [DEF_OPC_W-1:0] OPC_SAR = 4'd9;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DECODE,
      S_EXEC,
      S_WB
   } state_e;

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU for exec_controller. Results wrap modulo 2**DATA_W;
// v flags signed overflow on ADD/SUB only; illegal flags undefined opcodes.
module exec_alu
   import exec_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned OPC_W  = DEF_OPC_W
) (
   input  logic [OPC_W-1:0]  opc,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] imm,
   output logic [DATA_W-1:0] result,
   output logic              v,
   output logic              illegal
);

   // Opcode decode and result selection
   always_comb begin
      result  = '0;
      v       = 1'b0;
      illegal = 1'b0;
      case (opc)
         OPC_NOP: begin
            result = '0;
         end
         OPC_ADD: begin
            result = a + b;
            v      = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
         end
         OPC_SUB: begin
            result = a - b;
            v      = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
         end
         OPC_AND: result = a & b;
         OPC_OR:  result = a | b;
         OPC_XOR: result = a ^ b;
         OPC_LDI: result = imm;
         OPC_MOV: result = a;
         OPC_SHL: result = {a[DATA_W-2:0], 1'b0};
         OPC_SAR: result = {a[DATA_W-1], a[DATA_W-1:1]};
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/exec_controller.sv
// Single-issue sequencer for the 4x8 register file:
// IDLE -> DECODE -> EXEC -> WB -> IDLE, one instruction per four cycles.
// Optional feature macro: STATUS_FLAGS_EN adds flag_z/flag_n/flag_v outputs,
// updated on the writeback commit edge.
module exec_controller
   import exec_pkg::*;
#(
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int unsigned OPC_W      = DEF_OPC_W
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic                                      instr_valid,
   output logic                                      instr_ready,
   input  logic [OPC_W+2*REG_ADDR_W+DATA_W-1:0]      instr,
   input  logic [DATA_W-1:0]                         operandA,
   input  logic [DATA_W-1:0]                         operandB,
   output logic [REG_ADDR_W-1:0]                     aReg_select,
   output logic [REG_ADDR_W-1:0]                     bReg_select,
   output logic [REG_ADDR_W-1:0]                     dest_select,
   output logic [DATA_W-1:0]                         reg_data,
   output logic                                      load_enable,
   output logic                                      busy,
   output logic                                      illegal_op
`ifdef STATUS_FLAGS_EN
   ,
   output logic                                      flag_z,
   output logic                                      flag_n,
   output logic                                      flag_v
`endif
);

   localparam int unsigned IW = OPC_W + 2 * REG_ADDR_W + DATA_W;

   state_e                  state_q, state_d;
   logic [IW-1:0]           instr_q, instr_d;
   logic [REG_ADDR_W-1:0]   a_sel_q, a_sel_d;
   logic [REG_ADDR_W-1:0]   b_sel_q, b_sel_d;
   logic [REG_ADDR_W-1:0]   dest_q, dest_d;
   logic [DATA_W-1:0]       op_a_q, op_a_d;
   logic [DATA_W-1:0]       op_b_q, op_b_d;
   logic [DATA_W-1:0]       result_q, result_d;
   logic                    le_q, le_d;
   logic                    busy_q, busy_d;
   logic                    ready_q, ready_d;
   logic                    illegal_q, illegal_d;

   logic [OPC_W-1:0]        opc;
   logic [REG_ADDR_W-1:0]   rd;
   logic [DATA_W-1:0]       imm;
   logic [DATA_W-1:0]       alu_result;
   logic                    alu_v;
   logic                    alu_illegal;

   assign opc = instr_q[IW-1 -: OPC_W];
   assign rd  = instr_q[IW-OPC_W-1 -: REG_ADDR_W];
   assign imm = instr_q[DATA_W-1:0];

   exec_alu #(
      .DATA_W (DATA_W),
      .OPC_W  (OPC_W)
   ) u_alu (
      .opc     (opc),
      .a       (op_a_q),
      .b       (op_b_q),
      .imm     (imm),
      .result  (alu_result),
      .v       (alu_v),
      .illegal (alu_illegal)
   );

`ifdef STATUS_FLAGS_EN
   logic ovf_q, ovf_d;
   logic flag_z_q, flag_z_d;
   logic flag_n_q, flag_n_d;
   logic flag_v_q, flag_v_d;
`else
   logic unused_alu_v;
   assign unused_alu_v = alu_v;
`endif

   // Next-state and registered-output computation
   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      a_sel_d   = a_sel_q;
      b_sel_d   = b_sel_q;
      dest_d    = dest_q;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      result_d  = result_q;
      busy_d    = busy_q;
      ready_d   = ready_q;
      le_d      = 1'b0;
      illegal_d = 1'b0;
`ifdef STATUS_FLAGS_EN
      ovf_d     = ovf_q;
      flag_z_d  = flag_z_q;
      flag_n_d  = flag_n_q;
      flag_v_d  = flag_v_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               // read selects come straight from the incoming word so they are
               // already valid during DECODE
               instr_d = instr;
               a_sel_d = instr[DATA_W+REG_ADDR_W-1 -: REG_ADDR_W];
               b_sel_d = instr[REG_ADDR_W-1:0];
               state_d = S_DECODE;
               busy_d  = 1'b1;
               ready_d = 1'b0;
            end
         end
         S_DECODE: begin
            op_a_d    = operandA;
            op_b_d    = operandB;
            illegal_d = alu_illegal;
            state_d   = S_EXEC;
         end
         S_EXEC: begin
            if (opc == OPC_NOP || alu_illegal) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               ready_d = 1'b1;
            end else begin
               result_d = alu_result;
               dest_d   = rd;
               le_d     = 1'b1;
`ifdef STATUS_FLAGS_EN
               ovf_d    = alu_v;
`endif
               state_d  = S_WB;
            end
         end
         S_WB: begin
`ifdef STATUS_FLAGS_EN
            flag_z_d = (result_q == '0);
            flag_n_d = result_q[DATA_W-1];
            flag_v_d = ovf_q;
`endif
            state_d = S_IDLE;
            busy_d  = 1'b0;
            ready_d = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            ready_d = 1'b1;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         instr_q   <= '0;
         a_sel_q   <= '0;
         b_sel_q   <= '0;
         dest_q    <= '0;
         op_a_q    <= '0;
         op_b_q    <= '0;
         result_q  <= '0;
         le_q      <= 1'b0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b1;
         illegal_q <= 1'b0;
`ifdef STATUS_FLAGS_EN
         ovf_q     <= 1'b0;
         flag_z_q  <= 1'b0;
         flag_n_q  <= 1'b0;
         flag_v_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         a_sel_q   <= a_sel_d;
         b_sel_q   <= b_sel_d;
         dest_q    <= dest_d;
         op_a_q    <= op_a_d;
         op_b_q    <= op_b_d;
         result_q  <= result_d;
         le_q      <= le_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
         illegal_q <= illegal_d;
`ifdef STATUS_FLAGS_EN
         ovf_q     <= ovf_d;
         flag_z_q  <= flag_z_d;
         flag_n_q  <= flag_n_d;
         flag_v_q  <= flag_v_d;
`endif
      end
   end

   assign instr_ready = ready_q;
   assign busy        = busy_q;
   assign aReg_select = a_sel_q;
   assign bReg_select = b_sel_q;
   assign dest_select = dest_q;
   assign reg_data    = result_q;
   assign load_enable = le_q;
   assign illegal_op  = illegal_q;
`ifdef STATUS_FLAGS_EN
   assign flag_z      = flag_z_q;
   assign flag_n      = flag_n_q;
   assign flag_v      = flag_v_q;
`endif

endmodule

// File: tb/tb_exec_controller.sv
// Self-checking bench for exec_controller: directed cases followed by random
// instructions, compared against an arithmetic reference model of the ISA.
module tb_exec_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic [7:0]  operandA;
   logic [7:0]  operandB;
   logic [1:0]  aReg_select;
   logic [1:0]  bReg_select;
   logic [1:0]  dest_select;
   logic [7:0]  reg_data;
   logic        load_enable;
   logic        busy;
   logic        illegal_op;
`ifdef STATUS_FLAGS_EN
   logic        flag_z, flag_n, flag_v;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   exec_controller #(
      .DATA_W     (8),
      .REG_ADDR_W (2),
      .OPC_W      (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .operandA    (operandA),
      .operandB    (operandB),
      .aReg_select (aReg_select),
      .bReg_select (bReg_select),
      .dest_select (dest_select),
      .reg_data    (reg_data),
      .load_enable (load_enable),
      .busy        (busy),
      .illegal_op  (illegal_op)
`ifdef STATUS_FLAGS_EN
      ,
      .flag_z      (flag_z),
      .flag_n      (flag_n),
      .flag_v      (flag_v)
`endif
   );

   // Register file the controller drives
   logic [7:0] rf [4];
   always @(posedge clk) if (load_enable) rf[dest_select] <= reg_data;
   assign operandA = rf[aReg_select];
   assign operandB = rf[bReg_select];

   // Reference model state
   int ref_rf [4];
   int ref_z = 0, ref_n = 0, ref_v = 0;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] enc(input int opc, input int rd, input int ra, input int imm);
      logic [15:0] w;
      w = 16'((opc & 15) * 4096 + (rd & 3) * 1024 + (ra & 3) * 256 + (imm & 255));
      return w;
   endfunction

   // ISA semantics computed with signed integer arithmetic
   task automatic model(input logic [15:0] ins, output bit wb, output logic [7:0] res,
                        output bit ill, output bit v);
      int op, a, b, sa, sb, s;
      op = int'(ins[15:12]);
      a  = ref_rf[ins[9:8]];
      b  = ref_rf[ins[1:0]];
      sa = (a > 127) ? a - 256 : a;
      sb = (b > 127) ? b - 256 : b;
      wb = 1; ill = 0; v = 0; s = 0;
      case (op)
         0: wb = 0;
         1: begin s = sa + sb; v = (s > 127 || s < -128); end
         2: begin s = sa - sb; v = (s > 127 || s < -128); end
         3: s = a & b;
         4: s = a | b;
         5: s = a ^ b;
         6: s = int'(ins[7:0]);
         7: s = a;
         8: s = a * 2;
         9: s = (sa - (sa & 1)) / 2;
         default: begin wb = 0; ill = 1; end
      endcase
      res = s[7:0];
   endtask

   task automatic apply(input logic [15:0] ins, input bit wb, input logic [7:0] res, input bit v);
      if (wb) begin
         ref_rf[ins[11:10]] = int'(res);
         ref_z = (res == 8'd0) ? 1 : 0;
         ref_n = int'(res[7]);
         ref_v = int'(v);
      end
   endtask

   task automatic chk_flags(input string tag);
`ifdef STATUS_FLAGS_EN
      chk({tag, "_z"}, 32'(flag_z), 32'(ref_z));
      chk({tag, "_n"}, 32'(flag_n), 32'(ref_n));
      chk({tag, "_v"}, 32'(flag_v), 32'(ref_v));
`else
      if (tag.len() == 0) $display("empty flag tag");
`endif
   endtask

   task automatic wait_ready(input string tag);
      int guard = 0;
      while (!instr_ready && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      chk({tag, "_ready"}, 32'(instr_ready), 32'd1);
   endtask

   // Issue one instruction and follow it through to IDLE
   task automatic run(input string tag, input logic [15:0] ins, output logic [7:0] obs_data);
      bit wb, ill, v;
      logic [7:0] res;
      int le_cnt, le_k, il_cnt, il_k;
      logic [1:0] d_sel;
      model(ins, wb, res, ill, v);
      wait_ready(tag);
      instr_valid = 1'b1;
      instr = ins;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      instr = 16'($urandom);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_asel"}, 32'(aReg_select), 32'(ins[9:8]));
      chk({tag, "_bsel"}, 32'(bReg_select), 32'(ins[1:0]));
      le_cnt = 0; le_k = -1; il_cnt = 0; il_k = -1;
      obs_data = 8'h00; d_sel = 2'd0;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         if (load_enable) begin le_cnt++; le_k = k; obs_data = reg_data; d_sel = dest_select; end
         if (illegal_op)  begin il_cnt++; il_k = k; end
      end
      chk({tag, "_le_cnt"}, 32'(le_cnt), wb ? 32'd1 : 32'd0);
      if (wb) begin
         chk({tag, "_le_cycle"}, 32'(le_k), 32'd2);
         chk({tag, "_dest"}, 32'(d_sel), 32'(ins[11:10]));
         chk({tag, "_data"}, 32'(obs_data), 32'(res));
      end
      chk({tag, "_ill_cnt"}, 32'(il_cnt), ill ? 32'd1 : 32'd0);
      if (ill) chk({tag, "_ill_cycle"}, 32'(il_k), 32'd1);
      chk({tag, "_idle"}, 32'({busy, instr_ready}), 32'b01);
      chk({tag, "_asel_hold"}, 32'(aReg_select), 32'(ins[9:8]));
      apply(ins, wb, res, v);
      chk_flags(tag);
   endtask

   logic [7:0] got;

   initial begin
      logic [15:0] i1, i2;
      bit wb1, wb2, il1, il2, v1, v2;
      logic [7:0] r1, r2;
      logic [7:0] dat [2];
      logic [1:0] dst [2];
      int le_n, low;

      reset = 1'b1;
      instr_valid = 1'b0;
      instr = 16'h0000;
      for (int r = 0; r < 4; r++) ref_rf[r] = 0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_le",    32'(load_enable), 32'd0);
      chk("rst_busy",  32'(busy),        32'd0);
      chk("rst_ready", 32'(instr_ready), 32'd1);
      chk("rst_sel",   32'({aReg_select, bReg_select, dest_select}), 32'd0);
      chk("rst_data",  32'(reg_data),    32'd0);
      chk("rst_ill",   32'(illegal_op),  32'd0);
      chk_flags("rst_flags");
      reset = 1'b0;
      @(posedge clk); #1;

      // Clear the register file via LDI
      for (int r = 0; r < 4; r++) run("init", enc(6, r, 0, 0), got);

      // LDI r1,130
      run("ldi", enc(6, 1, 0, 130), got);
      chk("ldi_const", 32'(got), 32'h82);

      // ADD r2 = r1 + r3 with 100 + 50
      run("ldi_a", enc(6, 1, 0, 100), got);
      run("ldi_b", enc(6, 3, 0, 50), got);
      run("add", enc(1, 2, 1, 3), got);
      chk("add_const", 32'(got), 32'h96);

      // SUB r0 = r1 - r1 with 7, then MOV r3 = r0
      run("ldi7", enc(6, 1, 0, 7), got);
      run("sub", enc(2, 0, 1, 1), got);
      chk("sub_const", 32'(got), 32'h00);
      run("mov", enc(7, 3, 0, 0), got);
      chk("mov_const", 32'(got), 32'h00);

      // Back-to-back ADDs with instr_valid held high
      i1 = enc(1, 0, 1, 2);
      i2 = enc(1, 1, 0, 0);
      model(i1, wb1, r1, il1, v1); apply(i1, wb1, r1, v1);
      model(i2, wb2, r2, il2, v2); apply(i2, wb2, r2, v2);
      wait_ready("b2b");
      instr_valid = 1'b1;
      instr = i1;
      @(posedge clk); #1;
      instr = i2;
      le_n = 0; low = 0;
      while (!instr_ready && low < 10) begin
         low++;
         if (load_enable) begin
            if (le_n < 2) begin dat[le_n] = reg_data; dst[le_n] = dest_select; end
            le_n++;
         end
         @(posedge clk); #1;
      end
      chk("b2b_ready_low", 32'(low), 32'd3);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      chk("b2b_second_accept", 32'(busy), 32'd1);
      chk("b2b_second_asel", 32'(aReg_select), 32'(i2[9:8]));
      for (int k = 0; k < 5; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         if (load_enable) begin
            if (le_n < 2) begin dat[le_n] = reg_data; dst[le_n] = dest_select; end
            le_n++;
         end
      end
      chk("b2b_le_total", 32'(le_n), 32'd2);
      if (le_n == 2) begin
         chk("b2b_data0", 32'(dat[0]), 32'(r1));
         chk("b2b_dest0", 32'(dst[0]), 32'(i1[11:10]));
         chk("b2b_data1", 32'(dat[1]), 32'(r2));
         chk("b2b_dest1", 32'(dst[1]), 32'(i2[11:10]));
      end
      chk_flags("b2b_flags");

      // Reset during EXEC drops the instruction
      wait_ready("rstx");
      instr_valid = 1'b1;
      instr = enc(1, 2, 2, 2);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(posedge clk); #1;
      chk("rstx_in_exec", 32'(busy), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rstx_le",    32'(load_enable), 32'd0);
      chk("rstx_idle",  32'({busy, instr_ready}), 32'b01);
      chk("rstx_sel",   32'({aReg_select, bReg_select, dest_select}), 32'd0);
      le_n = 0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         if (load_enable) le_n++;
      end
      chk("rstx_no_wb", 32'(le_n), 32'd0);
      ref_z = 0; ref_n = 0; ref_v = 0;
      chk_flags("rstx_flags");

      // Undefined opcode
      run("illegal", enc(15, 1, 2, 3), got);

      // Random registers then random instructions
      for (int r = 0; r < 4; r++) run("rinit", enc(6, r, 0, int'($urandom_range(0, 255))), got);
      for (int n = 0; n < 60; n++) run("rand", 16'($urandom), got);

      for (int r = 0; r < 4; r++) chk("final_rf", 32'(rf[r]), 32'(ref_rf[r]));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
